// File: rtl/pool_pkg.sv
// pool_pkg: shared FSM state type and RAM timing constant for the max pooler.
// Provides: pool_state_t (pooler FSM states), POOL_READ_LATENCY (cycles from read address to data).
package pool_pkg;
    typedef enum logic [3:0] {
        ST_WAIT,
        ST_REQ_0,
        ST_REQ_1,
        ST_REQ_2,
        ST_REQ_3,
        ST_LOAD_2,
        ST_LOAD_3,
        ST_WRITE,
        ST_FINISHED
    } pool_state_t;
    localparam int POOL_READ_LATENCY = 2;
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: window counters and read/write address generation for the 2x2 stride-2 max pooler.
// Ports: clk, reset (sync, active-high), init (restart at first window), advance (step to next window),
//        tl_addr (top-left read address of current window), write_address_out (output address),
//        last_window (current window is the final one of the map).
module pool_addr_gen #(
    parameter int IN_WIDTH   = 4,
    parameter int IN_HEIGHT  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_BASE  = 0,
    parameter int WRITE_BASE = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] tl_addr,
    output logic [ADDR_WIDTH-1:0] write_address_out,
    output logic                  last_window
);
    localparam int CW = $clog2(IN_WIDTH);
    localparam int RW = $clog2(IN_HEIGHT);
    logic [CW-1:0]         r_col_count;
    logic [RW-1:0]         r_row_count;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [ADDR_WIDTH-1:0] r_write_address;
    logic                  w_col_last;
    assign w_col_last        = r_col_count == CW'(IN_WIDTH / 2 - 1);
    assign last_window       = w_col_last && (r_row_count == RW'(IN_HEIGHT / 2 - 1));
    assign tl_addr           = r_row_base + ADDR_WIDTH'({r_col_count, 1'b0});
    assign write_address_out = r_write_address;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_count     <= '0;
            r_row_count     <= '0;
            r_row_base      <= '0;
            r_write_address <= ADDR_WIDTH'(WRITE_BASE);
        end else if (init) begin
            r_col_count     <= '0;
            r_row_count     <= '0;
            r_row_base      <= ADDR_WIDTH'(READ_BASE);
            r_write_address <= ADDR_WIDTH'(WRITE_BASE);
        end else if (advance) begin
            r_write_address <= r_write_address + ADDR_WIDTH'(1);
            r_col_count     <= w_col_last ? '0 : r_col_count + CW'(1);
            // a row of windows spans two input rows
            if (w_col_last) begin
                r_row_count <= r_row_count + RW'(1);
                r_row_base  <= r_row_base + ADDR_WIDTH'(2 * IN_WIDTH);
            end
        end
    end
endmodule

// File: rtl/max_pooler.sv
// max_pooler: signed 2x2 stride-2 max pooling from a shared feature RAM (2-cycle read latency) back into it.
// Ports: clk, reset (sync, active-high), run (start, sampled in WAIT), data_in (RAM read data),
//        read_address_out, result_out (pooled value), write_address_out, we_out, pool_done (1-cycle pulse).
// Option: define MAX_POOLER_RELU_EN to clamp negative pooled results to zero.
module max_pooler
    import pool_pkg::*;
#(
    parameter int IN_WIDTH   = 4,
    parameter int IN_HEIGHT  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_BASE  = 0,
    parameter int WRITE_BASE = 512
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic        [ADDR_WIDTH-1:0] read_address_out,
    output logic signed [DATA_WIDTH-1:0] result_out,
    output logic        [ADDR_WIDTH-1:0] write_address_out,
    output logic                         we_out,
    output logic                         pool_done
);
    pool_state_t                  r_state;
    pool_state_t                  w_next;
    logic signed [DATA_WIDTH-1:0] r_max;
    logic        [ADDR_WIDTH-1:0] w_tl;
    logic                         w_last;
    logic                         w_later_capture;
    pool_addr_gen #(
        .IN_WIDTH  (IN_WIDTH),
        .IN_HEIGHT (IN_HEIGHT),
        .ADDR_WIDTH(ADDR_WIDTH),
        .READ_BASE (READ_BASE),
        .WRITE_BASE(WRITE_BASE)
    ) u_addr (
        .clk              (clk),
        .reset            (reset),
        .init             (r_state == ST_WAIT && run),
        .advance          (r_state == ST_WRITE),
        .tl_addr          (w_tl),
        .write_address_out(write_address_out),
        .last_window      (w_last)
    );
    always_comb begin
        w_next           = r_state;
        read_address_out = '0;
        case (r_state)
            ST_WAIT:     w_next = run ? ST_REQ_0 : ST_WAIT;
            ST_REQ_0: begin
                read_address_out = w_tl;
                w_next           = ST_REQ_1;
            end
            ST_REQ_1: begin
                read_address_out = w_tl + ADDR_WIDTH'(1);
                w_next           = ST_REQ_2;
            end
            ST_REQ_2: begin
                read_address_out = w_tl + ADDR_WIDTH'(IN_WIDTH);
                w_next           = ST_REQ_3;
            end
            ST_REQ_3: begin
                read_address_out = w_tl + ADDR_WIDTH'(IN_WIDTH + 1);
                w_next           = ST_LOAD_2;
            end
            ST_LOAD_2:   w_next = ST_LOAD_3;
            ST_LOAD_3:   w_next = ST_WRITE;
            ST_WRITE:    w_next = w_last ? ST_FINISHED : ST_REQ_0;
            ST_FINISHED: w_next = ST_WAIT;
            default:     w_next = ST_WAIT;
        endcase
    end
    always_ff @(posedge clk) begin
        r_state <= reset ? ST_WAIT : w_next;
    end
    assign we_out    = r_state == ST_WRITE;
    assign pool_done = r_state == ST_FINISHED;
    // data for an address issued in REQ_k arrives two states later, so REQ_2..LOAD_3 see TL, TR, BL, BR
    assign w_later_capture = r_state == ST_REQ_3 || r_state == ST_LOAD_2 || r_state == ST_LOAD_3;
    always_ff @(posedge clk) begin
        if (reset)
            r_max <= '0;
        else if (r_state == ST_REQ_2 || (w_later_capture && data_in > r_max))
            r_max <= data_in;
    end
`ifdef MAX_POOLER_RELU_EN
    assign result_out = r_max[DATA_WIDTH-1] ? '0 : r_max;
`else
    assign result_out = r_max;
`endif
endmodule

// File: tb/tb_max_pooler.sv
// tb_max_pooler: directed, table-driven check of max_pooler on a 4x4 and a 2x2 map with a 2-cycle RAM model.
module tb_max_pooler;
    typedef struct packed {
        logic [15:0][15:0] w;
        logic [3:0][15:0]  e;
    } vec_t;

    logic clk = 0;
    logic reset = 1;
    logic run_a = 0, run_b = 0;
    logic signed [15:0] din_a, d1_a, din_b, d1_b;
    logic [9:0] raddr_a, waddr_a, raddr_b, waddr_b;
    logic signed [15:0] res_a, res_b;
    logic we_a, we_b, done_a, done_b;
    logic signed [15:0] mem_a [1024];
    logic signed [15:0] mem_b [1024];

    int cyc;
    int tests, fails;
    int wr_n_a, done_n_a, wr_n_b, done_n_b;
    int wr_addr_a [64], wr_cyc_a [64], done_cyc_a [8];
    int wr_addr_b [64], wr_cyc_b [64], done_cyc_b [8];
    logic signed [15:0] wr_data_a [64], wr_data_b [64];
    vec_t vecs [4];
    string names [4];

    always #5 clk = ~clk;

    max_pooler #(.IN_WIDTH(4), .IN_HEIGHT(4), .DATA_WIDTH(16), .ADDR_WIDTH(10),
                 .READ_BASE(0), .WRITE_BASE(512)) dut_a (
        .clk(clk), .reset(reset), .run(run_a), .data_in(din_a),
        .read_address_out(raddr_a), .result_out(res_a), .write_address_out(waddr_a),
        .we_out(we_a), .pool_done(done_a));

    max_pooler #(.IN_WIDTH(2), .IN_HEIGHT(2), .DATA_WIDTH(16), .ADDR_WIDTH(10),
                 .READ_BASE(0), .WRITE_BASE(512)) dut_b (
        .clk(clk), .reset(reset), .run(run_b), .data_in(din_b),
        .read_address_out(raddr_b), .result_out(res_b), .write_address_out(waddr_b),
        .we_out(we_b), .pool_done(done_b));

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        d1_a  <= mem_a[raddr_a];
        din_a <= d1_a;
        d1_b  <= mem_b[raddr_b];
        din_b <= d1_b;
    end

    always @(posedge clk) begin
        if (we_a && wr_n_a < 64) begin
            wr_addr_a[wr_n_a] <= int'(waddr_a);
            wr_data_a[wr_n_a] <= res_a;
            wr_cyc_a[wr_n_a]  <= cyc;
            wr_n_a            <= wr_n_a + 1;
        end
        if (done_a && done_n_a < 8) begin
            done_cyc_a[done_n_a] <= cyc;
            done_n_a             <= done_n_a + 1;
        end
        if (we_b && wr_n_b < 64) begin
            wr_addr_b[wr_n_b] <= int'(waddr_b);
            wr_data_b[wr_n_b] <= res_b;
            wr_cyc_b[wr_n_b]  <= cyc;
            wr_n_b            <= wr_n_b + 1;
        end
        if (done_b && done_n_b < 8) begin
            done_cyc_b[done_n_b] <= cyc;
            done_n_b             <= done_n_b + 1;
        end
    end

    function automatic int relu(input int x);
`ifdef MAX_POOLER_RELU_EN
        return x < 0 ? 0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_win(input int v, input int win, input int a, input int b, input int c, input int d, input int e);
        vecs[v].w[win*4+0] = 16'(a);
        vecs[v].w[win*4+1] = 16'(b);
        vecs[v].w[win*4+2] = 16'(c);
        vecs[v].w[win*4+3] = 16'(d);
        vecs[v].e[win]     = 16'(relu(e));
    endtask

    // window win = wr*2+wc, position pos = dr*2+dc lands at row-major (2wr+dr, 2wc+dc)
    task automatic load_a(input int v);
        for (int win = 0; win < 4; win++)
            for (int pos = 0; pos < 4; pos++)
                mem_a[((win / 2) * 2 + pos / 2) * 4 + (win % 2) * 2 + pos % 2] = vecs[v].w[win*4+pos];
    endtask

    task automatic wait_done_a(input int target);
        for (int k = 0; k < 400; k++) begin
            if (done_n_a >= target) break;
            @(negedge clk);
        end
        chk("done_seen_a", int'(done_n_a >= target), 1);
    endtask

    task automatic check_writes_a(input string nm, input int v, input int n0, input int s, input int n, input int gap);
        chk({nm, "_nwrites"}, wr_n_a - n0, n);
        if (wr_n_a - n0 >= n)
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s_addr%0d", nm, i), wr_addr_a[n0+i], 512 + i % 4);
                chk($sformatf("%s_data%0d", nm, i), int'($signed(wr_data_a[n0+i])), int'($signed(vecs[v].e[i%4])));
                chk($sformatf("%s_cyc%0d", nm, i), wr_cyc_a[n0+i] - s, 7 * (i % 4 + 1) + gap * (i / 4));
            end
    endtask

    task automatic do_pass_a(input int v);
        int n0 = wr_n_a;
        int d0 = done_n_a;
        int s;
        load_a(v);
        @(negedge clk);
        run_a = 1;
        s = cyc;
        @(negedge clk);
        run_a = 0;
        wait_done_a(d0 + 1);
        check_writes_a(names[v], v, n0, s, 4, 0);
        if (done_n_a > d0) chk({names[v], "_done_cyc"}, done_cyc_a[d0] - s, 29);
    endtask

    initial begin
        int n0, d0, s, nr;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        names[0] = "ramp";
        set_win(0, 0, 0, 1, 4, 5, 5);
        set_win(0, 1, 2, 3, 6, 7, 7);
        set_win(0, 2, 8, 9, 12, 13, 13);
        set_win(0, 3, 10, 11, 14, 15, 15);
        names[1] = "signed";
        set_win(1, 0, -8, -3, -5, -20, -3);
        set_win(1, 1, 7, 7, 7, 7, 7);
        set_win(1, 2, -32768, -32768, -32768, -32767, -32767);
        set_win(1, 3, 1, -1, 100, -100, 100);
        names[2] = "position";
        set_win(2, 0, 9, 1, 2, 3, 9);
        set_win(2, 1, 1, 9, 2, 3, 9);
        set_win(2, 2, 1, 2, 9, 3, 9);
        set_win(2, 3, 1, 2, 3, 9, 9);
        names[3] = "extremes";
        set_win(3, 0, -6, -5, -7, -5, -5);
        set_win(3, 1, 0, -1, 0, -1, 0);
        set_win(3, 2, 32767, -32768, 0, 1, 32767);
        set_win(3, 3, -2, -1, -3, -4, -1);

        repeat (3) @(negedge clk);
        reset = 0;
        chk("rst_raddr", int'(raddr_a), 0);
        chk("rst_result", int'(res_a), 0);
        chk("rst_waddr", int'(waddr_a), 512);
        chk("rst_we", int'(we_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_waddr_b", int'(waddr_b), 512);

        for (int v = 0; v < 4; v++) do_pass_a(v);

        // reset during LOAD_2 of the second window (cycle 12 after run)
        load_a(0);
        @(negedge clk);
        run_a = 1;
        @(negedge clk);
        run_a = 0;
        repeat (11) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_we", int'(we_a), 0);
        chk("mid_rst_waddr", int'(waddr_a), 512);
        chk("mid_rst_raddr", int'(raddr_a), 0);
        chk("mid_rst_result", int'(res_a), 0);
        reset = 0;
        nr = wr_n_a;
        repeat (30) @(negedge clk);
        chk("mid_rst_idle_writes", wr_n_a - nr, 0);
        chk("mid_rst_idle_done", int'(done_a), 0);
        do_pass_a(0);

        // run held high through FINISHED: second pass restarts one cycle after WAIT
        n0 = wr_n_a;
        d0 = done_n_a;
        @(negedge clk);
        run_a = 1;
        s = cyc;
        repeat (40) @(negedge clk);
        run_a = 0;
        wait_done_a(d0 + 2);
        check_writes_a("b2b", 0, n0, s, 8, 30);
        if (done_n_a >= d0 + 2) begin
            chk("b2b_done1", done_cyc_a[d0] - s, 29);
            chk("b2b_done2", done_cyc_a[d0+1] - s, 59);
        end

        // minimal 2x2 map
        mem_b[0] = 16'sd3;
        mem_b[1] = -16'sd4;
        mem_b[2] = 16'sd10;
        mem_b[3] = 16'sd2;
        @(negedge clk);
        run_b = 1;
        s = cyc;
        @(negedge clk);
        run_b = 0;
        for (int k = 0; k < 100 && done_n_b < 1; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("mini_nwrites", wr_n_b, 1);
        chk("mini_ndone", done_n_b, 1);
        if (wr_n_b >= 1) begin
            chk("mini_addr", wr_addr_b[0], 512);
            chk("mini_data", int'($signed(wr_data_b[0])), relu(10));
            chk("mini_wcyc", wr_cyc_b[0] - s, 7);
        end
        if (done_n_b >= 1) chk("mini_done_cyc", done_cyc_b[0] - s, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
